mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares the single-port instruction/data memory between the fetch path (writes IR) and the data path (load/store micro-operations issued by the microprogrammed control unit). It accepts one request at a time over a req/gnt/rvalid handshake, drives the memory port for exactly one cycle, waits the memory's fixed read latency, and returns data to the winning requester. Data accesses have priority. A starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 10: memory address width.
- DATA_W, 16: memory word width; matches instruction width.
- MEM_LAT, 2: cycles from the mem_en cycle to valid mem_rdata. Legal range ≥1.
- STARVE_MAX, 3: consecutive lost arbitrations after which fetch wins.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests. If none, stay. If a request is present, latch the winner as owner, plus addr, we, and wdata, then go to ISSUE.
- Arbitration:
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt updates only in IDLE when a request is accepted:
  - Reset to 0 when fetch wins.
  - Increment (saturating at STARVE_MAX) when data wins while if_req is high.
  - Reset to 0 when data wins with if_req low.
- ISSUE, 1 cycle:
  - mem_en=1; mem_we = latched we (0 for fetch).
  - mem_addr/mem_wdata hold the latched values.
  - The owner's gnt = 1.
  - Load cnt = MEM_LAT-1, then go to WAIT.
- WAIT:
  - If cnt == 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
  - Otherwise, decrement cnt.
- RESP, 1 cycle: the owner's rvalid = 1, then go to IDLE.
- Write semantics:
  - Stores never alter d_rdata.
  - if_rdata changes only on fetch captures; d_rdata changes only on load captures.
- Request handling:
  - A request dropped before its gnt is legal and is ignored.
  - A request still high after gnt is a new request at the next IDLE.
- Requests arriving in ISSUE, WAIT, or RESP are not sampled until IDLE.

## Timing
- A request sampled in IDLE at cycle N gives:
  - gnt and mem_en at cycle N+1.
  - mem_rdata captured at cycle N+1+MEM_LAT.
  - rvalid at cycle N+2+MEM_LAT.
  - IDLE again at N+3+MEM_LAT.
- Peak throughput: one transaction per MEM_LAT+3 cycles.
- Reset values: state=IDLE, starve_cnt=0, cnt=0, and every output 0 (gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy).
- mem_addr/mem_wdata hold their last value outside ISSUE.
- rdata outputs hold until the next capture.
- Reset asserted mid-transaction: the next cycle is IDLE with all outputs 0. The in-flight read is discarded and no rvalid is produced.
- gnt, mem_en, and rvalid are never high for more than one consecutive cycle. Exactly one owner's gnt/rvalid is active per transaction.

## Test plan
- Fetch alone: MEM_LAT=2, mem[0x010]=0xABCD, if_req with if_addr=0x010 at cycle 0 -> if_gnt, mem_en, mem_addr=0x010 at cycle 1; if_rvalid with if_rdata=0xABCD at cycle 4; busy high cycles 1–4.
- Store then load: d_req, d_we=1, d_addr=0x020, d_wdata=0x1234 -> mem_we=1 at ISSUE, d_rvalid 3 cycles later with d_rdata unchanged. Then a load from 0x020 -> d_rdata=0x1234.
- Contention: if_req and d_req both held high continuously with STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; starve_cnt returns to 0 after each fetch grant.
- Withdrawn request: if_req pulsed high only during a cycle in WAIT of a data transaction -> no if_gnt and no if_rvalid.
- Reset mid-op: rst asserted in WAIT of a load -> the next cycle has all outputs 0 and busy=0; no d_rvalid ever appears; a new if_req then completes normally.
- MEM_LAT=1 corner: a single fetch -> gnt at N+1, rvalid at N+3, with correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data wins contention unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [STV_W-1:0]  r_starve;
  logic              r_own_d, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;
  logic              w_any, w_starved, w_pick_d;

  assign w_any     = d_req | if_req;
  assign w_starved = (r_starve == STV_W'(STARVE_MAX));
  assign w_pick_d  = d_req & ~(if_req & w_starved);

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = r_we;
        if_gnt = ~r_own_d;
        d_gnt  = r_own_d;
        w_next = WAIT;
      end
      WAIT: if (r_cnt == '0) w_next = RESP;
      RESP: begin
        if_rvalid = ~r_own_d;
        d_rvalid  = r_own_d;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_own_d    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_own_d <= w_pick_d;
          r_we    <= w_pick_d & d_we;
          r_addr  <= w_pick_d ? d_addr : if_addr;
          if (w_pick_d) r_wdata <= d_wdata;
          // Starvation only accrues while fetch is actually waiting.
          if (!w_pick_d)     r_starve <= '0;
          else if (if_req) begin
            if (!w_starved)  r_starve <= r_starve + STV_W'(1);
          end else           r_starve <= '0;
        end
        ISSUE: r_cnt <= CNT_W'(MEM_LAT - 1);
        WAIT: begin
          if (r_cnt == '0) begin
            if (!r_own_d)   r_if_rdata <= mem_rdata;
            else if (!r_we) r_d_rdata  <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus contention, withdrawal,
// mid-op reset and a MEM_LAT=1 instance.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [9:0]  if_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic        if_req1 = 1'b0;
  logic [9:0]  if_addr1 = '0;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [15:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [9:0]  mem_addr1;

  logic [15:0] mem [1024];
  logic [15:0] p_d [2];
  logic        p_v [2];
  logic [15:0] q_d;
  logic        q_v;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(10'h000), .d_wdata(16'h0000),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));

  // Read data is valid only in its exact latency slot, garbage otherwise.
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h010] <= 16'hABCD;
      mem[10'h030] <= 16'h7E57;
      mem[10'h040] <= 16'h5555;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    p_v[0] <= mem_en & ~mem_we;
    p_d[0] <= mem[mem_addr];
    p_v[1] <= p_v[0];
    p_d[1] <= p_d[0];
    q_v    <= mem_en1 & ~mem_we1;
    q_d    <= mem[mem_addr1];
  end
  assign mem_rdata  = p_v[LAT-1] ? p_d[LAT-1] : 16'hDEAD;
  assign mem_rdata1 = q_v ? q_d : 16'hDEAD;

  logic [6:0]  ctl;
  logic [57:0] dat;
  assign ctl = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy};
  assign dat = {if_rdata, d_rdata, mem_addr, mem_wdata};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        dreq, ifreq, we;
    logic [9:0]  daddr;
    logic [15:0] wdata;
    logic [9:0]  iaddr;
    logic        own_d, mwe;
    logic [9:0]  maddr;
    logic [15:0] exp_if, exp_d;
  } vec_t;

  task automatic apply(input vec_t v, input string tag);
    d_req = v.dreq; if_req = v.ifreq; d_we = v.we;
    d_addr = v.daddr; d_wdata = v.wdata; if_addr = v.iaddr;
    @(negedge clk);
    chk({tag, "_gnt"}, 64'({if_gnt, d_gnt}), 64'({~v.own_d, v.own_d}));
    chk({tag, "_issue"}, 64'({mem_en, mem_we, busy}), 64'({1'b1, v.mwe, 1'b1}));
    chk({tag, "_maddr"}, 64'(mem_addr), 64'(v.maddr));
    if (v.mwe) chk({tag, "_mwdata"}, 64'(mem_wdata), 64'(v.wdata));
    d_req = 1'b0; if_req = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      chk({tag, "_wait"}, 64'(ctl), 64'(7'b0000001));
    end
    @(negedge clk);
    chk({tag, "_rvalid"}, 64'({if_rvalid, d_rvalid}), 64'({~v.own_d, v.own_d}));
    chk({tag, "_rdata"}, 64'({if_rdata, d_rdata}), 64'({v.exp_if, v.exp_d}));
    @(negedge clk);
    chk({tag, "_idle"}, 64'(ctl), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t vr;
    string seq;
    int ng, nbad, nrv;
    logic prev;

    //          dreq  ifreq we    daddr    wdata     iaddr    own_d mwe   maddr    exp_if    exp_d
    vecs[0] = '{1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 10'h010, 1'b0, 1'b0, 10'h010, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 10'h020, 16'h1234, 10'h000, 1'b1, 1'b1, 10'h020, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 10'h020, 16'h0000, 10'h000, 1'b1, 1'b0, 10'h020, 16'hABCD, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 10'h040, 16'h0000, 10'h030, 1'b1, 1'b0, 10'h040, 16'hABCD, 16'h5555};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 10'h010, 16'h0000, 10'h000, 1'b1, 1'b0, 10'h010, 16'hABCD, 16'hABCD};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 10'h040, 1'b0, 1'b0, 10'h040, 16'h5555, 16'hABCD};

    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'(ctl), 64'(0));
    chk("reset_dat", 64'(dat), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held continuously.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h040; if_req = 1'b1; if_addr = 10'h010;
    seq = ""; ng = 0; nbad = 0; prev = 1'b0;
    for (int c = 0; c < 200 && ng < 8; c++) begin
      @(negedge clk);
      if (d_gnt)  seq = {seq, "D"};
      if (if_gnt) seq = {seq, "F"};
      if ((d_gnt && if_gnt) || ((d_gnt || if_gnt) && prev)) nbad++;
      prev = d_gnt | if_gnt;
      if (d_gnt || if_gnt) ng++;
    end
    d_req = 1'b0; if_req = 1'b0;
    n_checks++;
    if (seq != "DDDFDDDF") begin
      n_err++;
      $display("FAIL contention_order: got %s expected DDDFDDDF", seq);
    end
    chk("contention_pulses", 64'(nbad), 64'(0));
    repeat (4) @(negedge clk);
    chk("contention_idle", 64'(ctl), 64'(0));
    chk("contention_rdata", 64'({if_rdata, d_rdata}), 64'({16'hABCD, 16'h5555}));

    // Fetch request pulsed only while a load sits in WAIT.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h010;
    @(negedge clk);
    if_req = 1'b0;
    nbad = 0; nrv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_gnt || if_rvalid) nbad++;
      if (d_rvalid) nrv++;
    end
    chk("withdraw_no_fetch", 64'(nbad), 64'(0));
    chk("withdraw_d_rvalid", 64'(nrv), 64'(1));
    chk("withdraw_d_rdata", 64'(d_rdata), 64'(16'h1234));

    // Reset while a load is waiting on memory.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", 64'(ctl), 64'(0));
    chk("midrst_dat", 64'(dat), 64'(0));
    rst = 1'b0;
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_rvalid || busy) nrv++;
    end
    chk("midrst_quiet", 64'(nrv), 64'(0));
    vr = '{1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 10'h030, 1'b0, 1'b0, 10'h030, 16'h7E57, 16'h0000};
    apply(vr, "post_rst");

    // MEM_LAT=1 instance: gnt at N+1, rvalid at N+3.
    if_req1 = 1'b1; if_addr1 = 10'h010;
    @(negedge clk);
    chk("lat1_gnt", 64'({if_gnt1, mem_en1, busy1}), 64'(3'b111));
    chk("lat1_maddr", 64'(mem_addr1), 64'(10'h010));
    if_req1 = 1'b0;
    @(negedge clk);
    chk("lat1_wait", 64'({if_gnt1, if_rvalid1, mem_en1}), 64'(0));
    @(negedge clk);
    chk("lat1_rvalid", 64'({if_rvalid1, d_rvalid1}), 64'(2'b10));
    chk("lat1_rdata", 64'(if_rdata1), 64'(16'hABCD));
    @(negedge clk);
    chk("lat1_idle", 64'({busy1, if_rvalid1}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
